// File: rtl/req_encoder.sv
// Registered 4-to-2 request encoder: captures request lines into pending flags and issues
// each pending index once on a valid/ready port, round-robin or fixed-priority.
module req_encoder #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic [3:0] i,
    input  logic       rdy,
    output logic [1:0] o,
    output logic       v,
    output logic [3:0] pend,
    output logic       ovf
);

    logic [3:0] pend_q, pend_d;
    logic [1:0] o_q, o_d;
    logic [1:0] ptr_q, ptr_d;
    logic       v_q, v_d;
    logic       ovf_q, ovf_d;

    logic       load;
    logic       any;
    logic       found;
    logic [1:0] sel;
    logic [1:0] idx;
    logic [3:0] served;
    logic [3:0] req;

    assign load = ~v_q | rdy;
    assign any  = |pend_q;
    assign req  = i & {4{e}};

    // Search upward from ptr with wrap; ptr stays 0 in fixed-priority mode, giving lowest-first.
    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        o_d    = o_q;
        v_d    = v_q;
        ptr_d  = ptr_q;
        served = 4'b0000;
        if (load) begin
            if (any) begin
                o_d    = sel;
                v_d    = 1'b1;
                ptr_d  = RR ? sel + 2'd1 : 2'd0;
                served = 4'b0001 << sel;
            end else begin
                v_d = 1'b0;
            end
        end
    end

    // A bit served on this edge re-arms cleanly; only a still-pending bit overflows.
    always_comb begin
        pend_d = (pend_q & ~served) | req;
        ovf_d  = ovf_q | (|(req & pend_q & ~served));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            o_q    <= 2'd0;
            v_q    <= 1'b0;
            ptr_q  <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            o_q    <= o_d;
            v_q    <= v_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o    = o_q;
    assign v    = v_q;
    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule
